lifo_arbiter: RTL and testbench

- Shares one lifo stack instance between two requesters (client 0, client 1).
- Accepts push/pop requests over a req/gnt handshake and arbitrates round-robin.
- Drives the stack's write_en/read_en/din one transaction at a time, and returns pop data with a valid pulse.
- Rejects push-on-full and pop-on-empty with an error pulse; the stack is never strobed for a rejected request.

---
 rtl/lifo_arbiter.sv | 150 +++++++++++++++
 tb/tb_lifo_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lifo_arbiter
// Brief    : Round-robin arbiter sharing one LIFO stack between two clients;
//            rejects push-on-full / pop-on-empty and returns pop data.
// Revision : 1.0 - initial release
// ============================================================================
module lifo_arbiter #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             err0,
    output logic             err1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata,
    output logic             lifo_write_en,
    output logic             lifo_read_en,
    output logic [WIDTH-1:0] lifo_din,
    input  logic [WIDTH-1:0] lifo_dout,
    input  logic             lifo_empty,
    input  logic             lifo_full,
    output logic             busy
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_ISSUE   = 3'd1;
    localparam logic [2:0] c_S_CAPTURE = 3'd2;
    localparam logic [2:0] c_S_RESP    = 3'd3;
    localparam logic [2:0] c_S_REJECT  = 3'd4;

    generate
        if (STACK_DEPTH < 1) begin : g_depth_check
            $error("lifo_arbiter: STACK_DEPTH must be at least 1");
        end
    endgenerate

    logic [2:0] r_state;
    logic       r_owner;
    logic       r_op;
    logic       r_last;

    logic             w_any_req;
    logic             w_winner;
    logic             w_op;
    logic [WIDTH-1:0] w_data;
    logic             w_legal;

    // r_last holds the client served most recently; the other one wins a tie.
    always_comb begin
        w_any_req = req0 | req1;
        w_winner  = (req0 && req1) ? ~r_last : req1;
        w_op      = w_winner ? op1 : op0;
        w_data    = w_winner ? data1 : data0;
        w_legal   = w_op ? ~lifo_full : ~lifo_empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_S_IDLE;
            r_owner       <= 1'b0;
            r_op          <= 1'b0;
            r_last        <= 1'b1;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            rvalid0       <= 1'b0;
            rvalid1       <= 1'b0;
            rdata         <= '0;
            lifo_write_en <= 1'b0;
            lifo_read_en  <= 1'b0;
            lifo_din      <= '0;
            busy          <= 1'b0;
        end else begin
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            rvalid0       <= 1'b0;
            rvalid1       <= 1'b0;
            lifo_write_en <= 1'b0;
            lifo_read_en  <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_op    <= w_op;
                        r_last  <= w_winner;
                        busy    <= 1'b1;
                        if (w_legal) begin
                            r_state <= c_S_ISSUE;
                            gnt0    <= ~w_winner;
                            gnt1    <= w_winner;
                            if (w_op) begin
                                lifo_write_en <= 1'b1;
                                lifo_din      <= w_data;
                            end else begin
                                lifo_read_en  <= 1'b1;
                            end
                        end else begin
                            r_state <= c_S_REJECT;
                            err0    <= ~w_winner;
                            err1    <= w_winner;
                        end
                    end
                end
                c_S_ISSUE: begin
                    if (r_op) begin
                        r_state <= c_S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= c_S_CAPTURE;
                    end
                end
                // Stack output is registered, so it is valid only one cycle after read_en.
                c_S_CAPTURE: begin
                    rdata   <= lifo_dout;
                    rvalid0 <= ~r_owner;
                    rvalid1 <= r_owner;
                    r_state <= c_S_RESP;
                end
                c_S_RESP: begin
                    r_state <= c_S_IDLE;
                    busy    <= 1'b0;
                end
                c_S_REJECT: begin
                    r_state <= c_S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lifo_arbiter
// Brief    : Bench for lifo_arbiter with an attached stack and a
//            transaction-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lifo_arbiter;

    localparam int c_W     = 8;
    localparam int c_DEPTH = 16;
    localparam int c_NCYC  = 4096;

    logic clk;
    logic rst;
    logic req0, op0, req1, op1;
    logic [c_W-1:0] data0, data1;
    logic gnt0, gnt1, err0, err1, rvalid0, rvalid1;
    logic [c_W-1:0] rdata, lifo_din, lifo_dout;
    logic lifo_write_en, lifo_read_en, lifo_empty, lifo_full, busy;

    lifo_arbiter #(.WIDTH(c_W), .STACK_DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .data0(data0),
        .req1(req1), .op1(op1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .lifo_write_en(lifo_write_en), .lifo_read_en(lifo_read_en),
        .lifo_din(lifo_din), .lifo_dout(lifo_dout),
        .lifo_empty(lifo_empty), .lifo_full(lifo_full), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached stack: registered read data, shares the arbiter reset.
    logic [c_W-1:0] r_mem [0:c_DEPTH-1];
    logic [4:0]     r_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 5'd0;
            lifo_dout <= '0;
        end else if (lifo_write_en && r_cnt < 5'(c_DEPTH)) begin
            r_mem[r_cnt[3:0]] <= lifo_din;
            r_cnt             <= r_cnt + 5'd1;
        end else if (lifo_read_en && r_cnt > 5'd0) begin
            lifo_dout <= r_mem[4'(r_cnt - 5'd1)];
            r_cnt     <= r_cnt - 5'd1;
        end
    end
    assign lifo_empty = (r_cnt == 5'd0);
    assign lifo_full  = (r_cnt == 5'(c_DEPTH));

    // Reference: each decision schedules expected outputs on a cycle timeline.
    typedef struct {
        bit       gnt0, gnt1, err0, err1, rv0, rv1, we, re, busy, rd_set;
        bit [7:0] din, rd_val;
    } exp_t;

    exp_t     ex [0:c_NCYC-1];
    int       cyc;
    int       free_at;
    bit       m_last;
    bit [7:0] m_stk [$];
    bit [7:0] exp_rdata;
    int       n_tests;
    int       n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic sched(input int idx, input exp_t e);
        if (idx < c_NCYC) ex[idx] = e;
    endtask

    task automatic model_reset();
        for (int k = cyc; k < c_NCYC; k++) ex[k] = '{default: '0};
        free_at   = 0;
        m_last    = 1'b1;
        m_stk.delete();
        exp_rdata = 8'h00;
    endtask

    task automatic model_edge();
        bit       w, o;
        bit [7:0] d;
        exp_t     e0, e1, e2;
        if (!rst || cyc < free_at || !(req0 || req1)) return;
        w      = (req0 && req1) ? !m_last : req1;
        o      = w ? op1 : op0;
        d      = w ? data1 : data0;
        m_last = w;
        e0 = ex[cyc];
        e0.busy = 1'b1;
        if (o && m_stk.size() < c_DEPTH) begin
            e0.gnt0 = !w; e0.gnt1 = w; e0.we = 1'b1; e0.din = d;
            m_stk.push_back(d);
            free_at = cyc + 2;
        end else if (!o && m_stk.size() > 0) begin
            e0.gnt0 = !w; e0.gnt1 = w; e0.re = 1'b1;
            e1 = '{default: '0};
            e1.busy = 1'b1;
            e2 = '{default: '0};
            e2.busy = 1'b1; e2.rv0 = !w; e2.rv1 = w;
            e2.rd_set = 1'b1; e2.rd_val = m_stk.pop_back();
            sched(cyc + 1, e1);
            sched(cyc + 2, e2);
            free_at = cyc + 4;
        end else begin
            e0.err0 = !w; e0.err1 = w;
            free_at = cyc + 2;
        end
        sched(cyc, e0);
    endtask

    task automatic check_window();
        exp_t e;
        e = ex[cyc];
        if (e.rd_set) exp_rdata = e.rd_val;
        check("gnt0",    32'(gnt0),          32'(e.gnt0));
        check("gnt1",    32'(gnt1),          32'(e.gnt1));
        check("err0",    32'(err0),          32'(e.err0));
        check("err1",    32'(err1),          32'(e.err1));
        check("rvalid0", 32'(rvalid0),       32'(e.rv0));
        check("rvalid1", 32'(rvalid1),       32'(e.rv1));
        check("rdata",   32'(rdata),         32'(exp_rdata));
        check("wr_en",   32'(lifo_write_en), 32'(e.we));
        check("rd_en",   32'(lifo_read_en),  32'(e.re));
        check("busy",    32'(busy),          32'(e.busy));
        if (e.we) check("din", 32'(lifo_din), 32'(e.din));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_window();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0;
        rst  = 1'b0;
        model_reset();
        #1;
        check_window();
        run(2);
        rst = 1'b1;
    endtask

    task automatic drive(input logic g, input logic e, inout logic r, inout logic o,
                         inout logic [7:0] d, input int push_pct);
        if (r && (g || e)) begin
            r = 1'b0;
        end else if (!r && $urandom_range(0, 3) == 0) begin
            r = 1'b1;
            o = ($urandom_range(0, 99) < push_pct);
            d = 8'($urandom);
        end else if (r && $urandom_range(0, 7) == 0) begin
            o = ($urandom_range(0, 99) < push_pct);
            d = 8'($urandom);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        rst = 1'b0;
        req0 = 1'b0; op0 = 1'b0; data0 = '0;
        req1 = 1'b0; op1 = 1'b0; data1 = '0;
        for (int k = 0; k < c_NCYC; k++) ex[k] = '{default: '0};
        model_reset();
        run(2);
        rst = 1'b1;

        // Client 0 pushes 0x11 then 0x22; client 1 pops both back.
        req0 = 1'b1; op0 = 1'b1; data0 = 8'h11;
        step();
        data0 = 8'h22;
        run(2);
        req0 = 1'b0;
        run(3);
        req1 = 1'b1; op1 = 1'b0;
        run(5);
        req1 = 1'b0;
        run(5);

        // Both clients hold pushes: grants must alternate.
        do_reset();
        req0 = 1'b1; op0 = 1'b1; data0 = 8'hA0;
        req1 = 1'b1; op1 = 1'b1; data1 = 8'hB1;
        run(8);
        req0 = 1'b0; req1 = 1'b0;
        run(3);

        // Fill, push on full, then pop the 16th value.
        do_reset();
        req0 = 1'b1; op0 = 1'b1;
        for (int k = 0; k < c_DEPTH; k++) begin
            data0 = 8'(8'h40 + k);
            run(2);
        end
        data0 = 8'hFF;
        step();
        req0 = 1'b0;
        step();
        req1 = 1'b1; op1 = 1'b0;
        step();
        req1 = 1'b0;
        run(5);

        // Pop on empty right after reset.
        do_reset();
        req1 = 1'b1; op1 = 1'b0;
        step();
        req1 = 1'b0;
        run(3);

        // Reset during CAPTURE, then tie resolves to client 0.
        do_reset();
        req0 = 1'b1; op0 = 1'b1; data0 = 8'h5A;
        step();
        req0 = 1'b0;
        step();
        req1 = 1'b1; op1 = 1'b0;
        step();
        req1 = 1'b0;
        step();
        do_reset();
        req0 = 1'b1; op0 = 1'b1; data0 = 8'h33;
        req1 = 1'b1; op1 = 1'b1; data1 = 8'h44;
        step();
        req0 = 1'b0;
        run(2);
        req1 = 1'b0;
        run(3);

        // Randomized traffic, push-heavy then pop-heavy to hit both flags.
        do_reset();
        for (int i = 0; i < 2400; i++) begin
            step();
            drive(gnt0, err0, req0, op0, data0, (i < 1200) ? 75 : 25);
            drive(gnt1, err1, req1, op1, data1, (i < 1200) ? 75 : 25);
        end
        req0 = 1'b0; req1 = 1'b0;
        run(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
